// File: rtl/turn_scheduler.sv
// turn_scheduler: alternates cat/dog throw turns, launches the projectile, applies hits, declares the winner
// Optional aim-phase timeout is enabled by defining TURN_TIMEOUT_EN.
module turn_scheduler #(
   parameter int HP_INIT = 3,
   parameter int PAUSE_FRAMES = 30,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       frame_tick,
   input  logic       cat_throw_complete,
   input  logic       dog_throw_complete,
   input  logic       proj_done,
   input  logic       proj_hit_cat,
   input  logic       proj_hit_dog,
   output logic       cat_turn_active,
   output logic       dog_turn_active,
   output logic       proj_launch,
   output logic       proj_owner,
   output logic [2:0] cat_hp,
   output logic [2:0] dog_hp,
   output logic [7:0] turn_count,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [2:0] state_dbg
);
   localparam logic [2:0] IDLE = 3'd0, CAT_AIM = 3'd1, CAT_FLIGHT = 3'd2, DOG_AIM = 3'd3,
                          DOG_FLIGHT = 3'd4, PAUSE = 3'd5, GAME_OVER = 3'd6;
`ifdef TURN_TIMEOUT_EN
   localparam int CW = 10;
`else
   localparam int CW = 8;
`endif
   logic [2:0] state, nxt;
   logic [CW-1:0] frame_cnt;
   logic cat_q, dog_q, last_owner;
   logic cat_edge, dog_edge, pause_done, aim_timeout;
   logic cat_aim, dog_aim, restart, landed, timed_out;
   logic launch_d, owner_d, last_d;
   logic [2:0] cat_hp_d, dog_hp_d;
   logic [7:0] turn_d;
   logic [1:0] winner_d;
   assign state_dbg = state;
   assign cat_edge = cat_throw_complete & ~cat_q;
   assign dog_edge = dog_throw_complete & ~dog_q;
   assign cat_aim = state == CAT_AIM;
   assign dog_aim = state == DOG_AIM;
   assign pause_done = frame_tick && frame_cnt == CW'(PAUSE_FRAMES - 1);
`ifdef TURN_TIMEOUT_EN
   assign aim_timeout = frame_tick && frame_cnt == CW'(TIMEOUT_FRAMES - 1);
`else
   // timeout disabled: constant false, AIM states wait indefinitely
   assign aim_timeout = TIMEOUT_FRAMES < 0;
`endif
   // state register plus registered outputs derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cat_turn_active <= 1'b0;
         dog_turn_active <= 1'b0;
         game_over <= 1'b0;
         proj_launch <= 1'b0;
         proj_owner <= 1'b0;
         last_owner <= 1'b0;
         cat_hp <= 3'd0;
         dog_hp <= 3'd0;
         turn_count <= 8'd0;
         winner <= 2'b00;
      end else begin
         state <= nxt;
         cat_turn_active <= nxt == CAT_AIM;
         dog_turn_active <= nxt == DOG_AIM;
         game_over <= nxt == GAME_OVER;
         proj_launch <= launch_d;
         proj_owner <= owner_d;
         last_owner <= last_d;
         cat_hp <= cat_hp_d;
         dog_hp <= dog_hp_d;
         turn_count <= turn_d;
         winner <= winner_d;
      end
   end
   // throw edge detectors and frame counter that clears on every state entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cat_q <= 1'b0;
         dog_q <= 1'b0;
         frame_cnt <= '0;
      end else begin
         cat_q <= cat_throw_complete;
         dog_q <= dog_throw_complete;
         frame_cnt <= nxt != state ? '0 : frame_tick ? frame_cnt + CW'(1) : frame_cnt;
      end
   end
   // next-state logic; a throw edge beats a same-cycle timeout
   always_comb begin
      nxt = state;
      case (state)
         IDLE, GAME_OVER:        nxt = start ? CAT_AIM : state;
         CAT_AIM:                nxt = cat_edge ? CAT_FLIGHT : aim_timeout ? PAUSE : CAT_AIM;
         DOG_AIM:                nxt = dog_edge ? DOG_FLIGHT : aim_timeout ? PAUSE : DOG_AIM;
         CAT_FLIGHT, DOG_FLIGHT: nxt = proj_done ? PAUSE : state;
         PAUSE:                  nxt = !pause_done ? PAUSE :
                                       (cat_hp == 3'd0 || dog_hp == 3'd0) ? GAME_OVER :
                                       last_owner ? CAT_AIM : DOG_AIM;
         default:                nxt = IDLE;
      endcase
   end
   // datapath next values: launch, hits, turn counting, winner; a timed-out player counts as the last thrower
   always_comb begin
      restart = (state == IDLE || state == GAME_OVER) && start;
      landed = (state == CAT_FLIGHT || state == DOG_FLIGHT) && proj_done;
      timed_out = ((cat_aim && !cat_edge) || (dog_aim && !dog_edge)) && aim_timeout;
      launch_d = (cat_aim && cat_edge) || (dog_aim && dog_edge);
      owner_d = launch_d ? dog_aim : proj_owner;
      last_d = (cat_aim || dog_aim) && nxt != state ? dog_aim : last_owner;
      cat_hp_d = restart ? 3'(HP_INIT) : landed && proj_hit_cat && cat_hp != 3'd0 ? cat_hp - 3'd1 : cat_hp;
      dog_hp_d = restart ? 3'(HP_INIT) : landed && proj_hit_dog && dog_hp != 3'd0 ? dog_hp - 3'd1 : dog_hp;
      turn_d = restart ? 8'd0 : landed || timed_out ? turn_count + 8'd1 : turn_count;
      winner_d = restart ? 2'b00 : state == PAUSE && nxt == GAME_OVER ? {cat_hp == 3'd0, dog_hp == 3'd0} : winner;
   end
endmodule
